// File: rtl/fft16_iter.sv
// fft16_iter: iterative 16-point radix-2 DIT FFT with a single time-shared butterfly
module fft16_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fir_valid,
    input  logic [15:0] fir_d,
    output logic        fir_ready,
    output logic        fft_valid,
    output logic [31:0] fft_d0,
    output logic [31:0] fft_d1,
    output logic [31:0] fft_d2,
    output logic [31:0] fft_d3,
    output logic [31:0] fft_d4,
    output logic [31:0] fft_d5,
    output logic [31:0] fft_d6,
    output logic [31:0] fft_d7,
    output logic [31:0] fft_d8,
    output logic [31:0] fft_d9,
    output logic [31:0] fft_d10,
    output logic [31:0] fft_d11,
    output logic [31:0] fft_d12,
    output logic [31:0] fft_d13,
    output logic [31:0] fft_d14,
    output logic [31:0] fft_d15
);
    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;
    localparam logic signed [15:0] WR [8] = '{16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
                                               16'sd0, -16'sd6270, -16'sd11585, -16'sd15137};
    localparam logic signed [15:0] WI [8] = '{16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
                                               -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270};
    state_t state, state_nx;
    logic [15:0] smp [16];
    logic [4:0] count;
    logic [4:0] step;
    logic signed [15:0] re_q [16];
    logic signed [15:0] im_q [16];
    logic [31:0] out_q [16];
    logic transfer, do_bfly, do_out;
    logic [1:0] s;
    logic [2:0] b;
    logic [3:0] hm, top, bot;
    logic [2:0] t;
    logic signed [15:0] tr, ti, br, bi, wr, wi, pr, pi;
    logic signed [33:0] pr_w, pi_w;

    assign fir_ready = (count != 5'd16);

    // sample capture into the load buffer; data needs no reset
    always_ff @(posedge clk) begin
        if (fir_valid && fir_ready) smp[count[3:0]] <= fir_d;
    end

    // frame fill counter, cleared when the frame moves to the work array
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (transfer) count <= '0;
        else if (fir_valid && fir_ready) count <= count + 5'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // FSM next state: 32 butterflies then a single output cycle
    always_comb begin
        state_nx = (state == IDLE) ? (transfer ? COMPUTE : IDLE) :
                   (state == COMPUTE) ? ((step == 5'd31) ? OUT : COMPUTE) : IDLE;
    end

    // FSM outputs: per-cycle engine actions
    always_comb begin
        transfer = (state == IDLE) && (count == 5'd16);
        do_bfly = (state == COMPUTE);
        do_out = (state == OUT);
    end

    // butterfly addressing, twiddle lookup and rounded complex product
    always_comb begin
        s = step[4:3];
        b = step[2:0];
        hm = (4'd1 << s) - 4'd1;
        top = ((4'(b) >> s) << s << 1) | (4'(b) & hm);
        bot = top | (4'd1 << s);
        t = 3'((4'(b) & hm) << (2'd3 - s));
        tr = re_q[top];
        ti = im_q[top];
        br = re_q[bot];
        bi = im_q[bot];
        wr = WR[t];
        wi = WI[t];
        pr_w = 34'(br) * 34'(wr) - 34'(bi) * 34'(wi) + 34'sd8192;
        pi_w = 34'(br) * 34'(wi) + 34'(bi) * 34'(wr) + 34'sd8192;
        pr = 16'(pr_w >>> 14);
        pi = 16'(pi_w >>> 14);
    end

    // work array: bit-reversed load on transfer, in-place butterflies while computing
    always_ff @(posedge clk) begin
        if (transfer) begin
            for (int k = 0; k < 16; k++) begin
                re_q[{k[0], k[1], k[2], k[3]}] <= smp[k];
                im_q[k] <= '0;
            end
        end else if (do_bfly) begin
            re_q[top] <= tr + pr;
            im_q[top] <= ti + pi;
            re_q[bot] <= tr - pr;
            im_q[bot] <= ti - pi;
        end
    end

    // butterfly sequencer and registered result bank with valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            fft_valid <= 1'b0;
            for (int k = 0; k < 16; k++) out_q[k] <= '0;
        end else begin
            step <= do_bfly ? step + 5'd1 : 5'd0;
            fft_valid <= do_out;
            if (do_out) for (int k = 0; k < 16; k++) out_q[k] <= {re_q[k], im_q[k]};
        end
    end

    assign fft_d0 = out_q[0];
    assign fft_d1 = out_q[1];
    assign fft_d2 = out_q[2];
    assign fft_d3 = out_q[3];
    assign fft_d4 = out_q[4];
    assign fft_d5 = out_q[5];
    assign fft_d6 = out_q[6];
    assign fft_d7 = out_q[7];
    assign fft_d8 = out_q[8];
    assign fft_d9 = out_q[9];
    assign fft_d10 = out_q[10];
    assign fft_d11 = out_q[11];
    assign fft_d12 = out_q[12];
    assign fft_d13 = out_q[13];
    assign fft_d14 = out_q[14];
    assign fft_d15 = out_q[15];
endmodule

// File: tb/tb_fft16_iter.sv
// tb_fft16_iter: directed and randomized checks of fft16_iter against a textbook FFT model
module tb_fft16_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fir_valid = 1'b0;
    logic [15:0] fir_d = '0;
    logic fir_ready, fft_valid;
    logic [31:0] d [16];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [511:0] got_q [$];
    int vcyc_q [$];
    logic [511:0] mon_v;
    logic [15:0] stim [48];
    int acc_edge [48];
    int wr_t [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    int wi_t [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

    fft16_iter dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .fir_ready(fir_ready), .fft_valid(fft_valid),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fft_valid) begin
            for (int k = 0; k < 16; k++) mon_v[k*32 +: 32] = d[k];
            got_q.push_back(mon_v);
            vcyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wrap16(input longint v);
        logic signed [15:0] w;
        w = v[15:0];
        return int'(w);
    endfunction

    function automatic logic [511:0] ref_fft(input int off);
        int re [16];
        int im [16];
        int a, bb, tw, pr, pi, ur, ui;
        logic [511:0] r;
        for (int n = 0; n < 16; n++) begin
            a = ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
            re[a] = int'($signed(stim[off + n]));
            im[a] = 0;
        end
        for (int len = 2; len <= 16; len *= 2)
            for (int i = 0; i < 16; i += len)
                for (int j = 0; j < len / 2; j++) begin
                    a = i + j;
                    bb = a + len / 2;
                    tw = j * 16 / len;
                    pr = wrap16((longint'(re[bb]) * wr_t[tw] - longint'(im[bb]) * wi_t[tw] + 8192) >>> 14);
                    pi = wrap16((longint'(re[bb]) * wi_t[tw] + longint'(im[bb]) * wr_t[tw] + 8192) >>> 14);
                    ur = re[a];
                    ui = im[a];
                    re[a] = wrap16(ur + pr);
                    im[a] = wrap16(ui + pi);
                    re[bb] = wrap16(ur - pr);
                    im[bb] = wrap16(ui - pi);
                end
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = {re[k][15:0], im[k][15:0]};
        return r;
    endfunction

    task automatic send(input int cnt);
        int n = 0;
        int guard = 0;
        logic acc;
        while (n < cnt && guard < 400) begin
            fir_valid = 1'b1;
            fir_d = stim[n];
            acc = fir_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_edge[n] = cyc;
                n++;
            end
            guard++;
        end
        fir_valid = 1'b0;
        chk("samples accepted", n, cnt);
    endtask

    task automatic get_result(output logic [511:0] r, output int vc);
        int g = 0;
        while (got_q.size() == 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("result arrived", got_q.size() > 0, 1);
        r = '0;
        vc = 0;
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            vc = vcyc_q.pop_front();
        end
    endtask

    task automatic check_frame(input string tag, input logic [511:0] r, input logic [511:0] e);
        for (int k = 0; k < 16; k++) chk($sformatf("%s bin%0d", tag, k), r[k*32 +: 32], e[k*32 +: 32]);
    endtask

    task automatic fill_const(input logic [15:0] v, input logic alt);
        for (int n = 0; n < 16; n++) stim[n] = (alt && n[0]) ? -v : v;
    endtask

    task automatic const_frame(input string tag, input int hot, input logic [31:0] hv, input logic [31:0] rest);
        logic [511:0] r, e;
        int vc;
        send(16);
        get_result(r, vc);
        for (int k = 0; k < 16; k++) e[k*32 +: 32] = (k == hot) ? hv : rest;
        check_frame(tag, r, e);
    endtask

    initial begin
        logic [511:0] r, e0, e1, e2;
        int vc, vc1, ed;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset fir_ready", fir_ready, 1);
        chk("reset fft_valid", fft_valid, 0);
        chk("reset fft_d0", d[0], 0);
        chk("reset fft_d15", d[15], 0);

        fill_const(16'd0, 1'b0);
        stim[0] = 16'd100;
        send(16);
        ed = acc_edge[15];
        chk("ready low after 16th", fir_ready, 0);
        @(posedge clk);
        #1;
        chk("ready back after transfer", fir_ready, 1);
        get_result(r, vc);
        chk("impulse latency", vc - ed, 34);
        for (int k = 0; k < 16; k++) e0[k*32 +: 32] = 32'h0064_0000;
        check_frame("impulse", r, e0);
        @(posedge clk);
        #1;
        chk("valid is one cycle", fft_valid, 0);
        chk("outputs held", d[5], 32'h0064_0000);

        fill_const(16'd100, 1'b0);
        const_frame("dc", 0, 32'h0640_0000, 32'h0);
        fill_const(16'd100, 1'b1);
        const_frame("nyquist", 8, 32'h0640_0000, 32'h0);
        fill_const(16'd4096, 1'b0);
        const_frame("wrap", 0, 32'h0, 32'h0);

        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 16; n++) stim[n] = (f < 2) ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom);
            e0 = ref_fft(0);
            send(16);
            get_result(r, vc);
            check_frame($sformatf("random%0d", f), r, e0);
        end

        for (int n = 0; n < 48; n++) stim[n] = 16'($urandom_range(0, 8191) - 4096);
        e0 = ref_fft(0);
        e1 = ref_fft(16);
        e2 = ref_fft(32);
        send(48);
        get_result(r, vc1);
        check_frame("bp frame0", r, e0);
        chk("bp gap after 16th", acc_edge[16] - acc_edge[15], 2);
        chk("bp frame0 latency", vc1 - acc_edge[15], 34);
        chk("bp stall until done", acc_edge[32] - vc1, 2);
        get_result(r, vc);
        check_frame("bp frame1", r, e1);
        get_result(r, vc);
        check_frame("bp frame2", r, e2);

        for (int n = 0; n < 16; n++) stim[n] = 16'($urandom);
        send(16);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("abort no valid", got_q.size(), 0);
        chk("abort fir_ready", fir_ready, 1);
        chk("abort fft_d0", d[0], 0);
        chk("abort fft_d9", d[9], 0);
        fill_const(16'd0, 1'b0);
        stim[0] = 16'd100;
        const_frame("post-abort impulse", 0, 32'h0064_0000, 32'h0064_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
